// File: rtl/nes_poll_controller.sv
// ---------------------------------------------------------------------------
// nes_poll_controller
//
// Drives the NES pad's 4021 parallel-in/serial-out shift register once per
// poll strobe: pulses nes_latch, clocks out NUM_BITS serial bits with
// NUM_BITS-1 nes_clk pulses, samples nes_data through a 2-flop synchronizer
// and publishes an active-high button vector with a one-cycle valid pulse.
//
// Optional feature macro: NES_EDGE_DETECT_EN
//   defined   -> pressed pulses (with valid) the newly pressed buttons
//   undefined -> pressed is tied to zero, no edge logic is built
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   poll       in   1-cycle start strobe (frame_end); accepted only when idle
//   nes_data   in   serial pad data, active-low, asynchronous to clk
//   nes_latch  out  latch pulse to pad (LATCH_CYC cycles)
//   nes_clk    out  shift clock to pad, idles low
//   busy       out  high from the cycle after an accepted poll until valid
//   valid      out  1-cycle pulse when buttons is updated
//   buttons    out  active-high pressed vector, bit i = i-th serial bit
//   pressed    out  newly pressed buttons, pulses with valid
// ---------------------------------------------------------------------------
module nes_poll_controller #(
    parameter int LATCH_CYC = 300,
    parameter int HALF_CYC  = 150,
    parameter int NUM_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                poll,
    input  logic                nes_data,
    output logic                nes_latch,
    output logic                nes_clk,
    output logic                busy,
    output logic                valid,
    output logic [NUM_BITS-1:0] buttons,
    output logic [NUM_BITS-1:0] pressed
);

    localparam int TMAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = $clog2(NUM_BITS + 1);

    localparam logic [TW-1:0] LATCH_LOAD = TW'(LATCH_CYC - 1);
    localparam logic [TW-1:0] HALF_LOAD  = TW'(HALF_CYC - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(NUM_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE    = BW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CLK_HI = 3'd3,
        ST_CLK_LO = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t                state_r;
    logic [TW-1:0]         timer_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [NUM_BITS-1:0]   shift_r;
    logic                  sync_meta_r;
    logic                  sync_data_r;
    logic                  latch_r;
    logic                  nclk_r;
    logic                  busy_r;
    logic                  valid_r;
    logic [NUM_BITS-1:0]   buttons_r;

    logic                  sample_bit_s;
    logic                  timer_zero_s;
    logic                  last_bit_s;
    logic [NUM_BITS-1:0]   shift_next_s;

    // Two-flop synchronizer for the asynchronous pad data line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_meta_r <= 1'b0;
            sync_data_r <= 1'b0;
        end else begin
            sync_meta_r <= nes_data;
            sync_data_r <= sync_meta_r;
        end
    end

    // Timer / bit-count decodes; pad wire is active-low so invert the sample
    always_comb begin
        timer_zero_s = (timer_r == {TW{1'b0}});
        last_bit_s   = (bit_cnt_r == LAST_BIT);
        sample_bit_s = ~sync_data_r;
    end

    // First serial bit ends up in bit 0 after NUM_BITS right shifts
    generate
        if (NUM_BITS == 1) begin : g_shift_one
            // Single-bit poll: the sample is the whole vector
            always_comb begin
                shift_next_s = sample_bit_s;
            end
        end else begin : g_shift_multi
            // Shift the new sample in from the top
            always_comb begin
                shift_next_s = {sample_bit_s, shift_r[NUM_BITS-1:1]};
            end
        end
    endgenerate

    // Poll sequencer with registered pad pins and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            timer_r   <= {TW{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            shift_r   <= {NUM_BITS{1'b0}};
            latch_r   <= 1'b0;
            nclk_r    <= 1'b0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            buttons_r <= {NUM_BITS{1'b0}};
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (poll) begin
                        state_r   <= ST_LATCH;
                        timer_r   <= LATCH_LOAD;
                        bit_cnt_r <= {BW{1'b0}};
                        latch_r   <= 1'b1;
                        busy_r    <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (timer_zero_s) begin
                        state_r <= ST_SETTLE;
                        timer_r <= HALF_LOAD;
                        latch_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r - TIMER_ONE;
                    end
                end
                // Both low phases sample on their last cycle
                ST_SETTLE, ST_CLK_LO: begin
                    if (timer_zero_s) begin
                        shift_r <= shift_next_s;
                        if (last_bit_s) begin
                            // Final bit goes straight into buttons so the
                            // vector is published whole in the DONE cycle
                            state_r   <= ST_DONE;
                            buttons_r <= shift_next_s;
                            valid_r   <= 1'b1;
                            busy_r    <= 1'b0;
                        end else begin
                            state_r   <= ST_CLK_HI;
                            timer_r   <= HALF_LOAD;
                            bit_cnt_r <= bit_cnt_r + BIT_ONE;
                            nclk_r    <= 1'b1;
                        end
                    end else begin
                        timer_r <= timer_r - TIMER_ONE;
                    end
                end
                ST_CLK_HI: begin
                    if (timer_zero_s) begin
                        state_r <= ST_CLK_LO;
                        timer_r <= HALF_LOAD;
                        nclk_r  <= 1'b0;
                    end else begin
                        timer_r <= timer_r - TIMER_ONE;
                    end
                end
                ST_DONE: begin
                    // Polls arriving here are dropped
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    latch_r <= 1'b0;
                    nclk_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign nes_latch = latch_r;
    assign nes_clk   = nclk_r;
    assign busy      = busy_r;
    assign valid     = valid_r;
    assign buttons   = buttons_r;

`ifdef NES_EDGE_DETECT_EN
    logic                finish_s;
    logic [NUM_BITS-1:0] pressed_r;

    // Same condition that launches the DONE cycle
    always_comb begin
        finish_s = ((state_r == ST_SETTLE) || (state_r == ST_CLK_LO)) &&
                   timer_zero_s && last_bit_s;
    end

    // Newly pressed buttons against the previously published vector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pressed_r <= {NUM_BITS{1'b0}};
        end else if (finish_s) begin
            pressed_r <= shift_next_s & ~buttons_r;
        end else begin
            pressed_r <= {NUM_BITS{1'b0}};
        end
    end

    assign pressed = pressed_r;
`else
    assign pressed = {NUM_BITS{1'b0}};
`endif

endmodule

// File: tb/tb_nes_poll_controller.sv
// ---------------------------------------------------------------------------
// tb_nes_poll_controller
//
// Scoreboard bench: stimulus pushes each accepted poll (start cycle and pad
// pattern) into a queue; a monitor on the falling edge derives the expected
// pin waveform from the poll's age and pops the entry when valid is due,
// comparing buttons and pressed. A 4021 pad model drives nes_data.
// ---------------------------------------------------------------------------
module tb_nes_poll_controller;

    localparam int  LATCH = 300;
    localparam int  HALF  = 150;
    localparam int  NB    = 8;
    localparam int  LAT   = LATCH + (2 * NB - 1) * HALF + 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       poll  = 1'b0;
    logic       nes_data;
    logic       nes_latch;
    logic       nes_clk;
    logic       busy;
    logic       valid;
    logic [7:0] buttons;
    logic [7:0] pressed;

    always #5 clk = ~clk;

    nes_poll_controller #(
        .LATCH_CYC (LATCH),
        .HALF_CYC  (HALF),
        .NUM_BITS  (NB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .poll      (poll),
        .nes_data  (nes_data),
        .nes_latch (nes_latch),
        .nes_clk   (nes_clk),
        .busy      (busy),
        .valid     (valid),
        .buttons   (buttons),
        .pressed   (pressed)
    );

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reset as seen by the DUT at the last rising edge
    logic rst_q = 1'b0;
    always @(posedge clk) rst_q <= rst_n;

    // 4021 pad model: latch loads, each nes_clk rise shifts the next button out
    logic [7:0] pad_pattern = 8'h00;
    int         pad_idx     = 0;
    always @(posedge nes_latch or posedge nes_clk) begin
        if (nes_latch) pad_idx <= 0;
        else           pad_idx <= pad_idx + 1;
    end
    assign nes_data = (pad_idx < NB) ? ~pad_pattern[pad_idx[2:0]] : 1'b0;

    typedef struct {
        longint     start;
        logic [7:0] pat;
    } exp_t;

    exp_t       sb_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] model_buttons = 8'h00;
    bit         end_req  = 1'b0;
    bit         end_done = 1'b0;
    longint     free_at  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, want);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        longint     o;
        logic       act;
        logic       e_latch;
        logic       e_clk;
        logic       e_busy;
        logic       e_valid;
        logic [7:0] e_prs;
        if (!rst_q) begin
            sb_q.delete();
            model_buttons = 8'h00;
            chk("rst_latch",   {31'd0, nes_latch}, 32'd0);
            chk("rst_clk",     {31'd0, nes_clk},   32'd0);
            chk("rst_busy",    {31'd0, busy},      32'd0);
            chk("rst_valid",   {31'd0, valid},     32'd0);
            chk("rst_buttons", {24'd0, buttons},   32'd0);
            chk("rst_pressed", {24'd0, pressed},   32'd0);
        end else begin
            act = (sb_q.size() > 0) && (cyc > sb_q[0].start);
            o   = act ? (cyc - sb_q[0].start) : 64'd0;
            e_latch = act && (o <= LATCH);
            e_clk   = act && (o > LATCH) && (o < LAT) && ((((o - LATCH - 1) / HALF) % 2) == 1);
            e_busy  = act && (o < LAT);
            e_valid = act && (o == LAT);
            chk("nes_latch", {31'd0, nes_latch}, {31'd0, e_latch});
            chk("nes_clk",   {31'd0, nes_clk},   {31'd0, e_clk});
            chk("busy",      {31'd0, busy},      {31'd0, e_busy});
            chk("valid",     {31'd0, valid},     {31'd0, e_valid});
            if (e_valid) begin
`ifdef NES_EDGE_DETECT_EN
                e_prs = sb_q[0].pat & ~model_buttons;
`else
                e_prs = 8'h00;
`endif
                chk("buttons", {24'd0, buttons}, {24'd0, sb_q[0].pat});
                chk("pressed", {24'd0, pressed}, {24'd0, e_prs});
                model_buttons = sb_q[0].pat;
                void'(sb_q.pop_front());
            end else begin
                chk("buttons_hold", {24'd0, buttons}, {24'd0, model_buttons});
                chk("pressed_idle", {24'd0, pressed}, 32'd0);
            end
        end
        if (end_req && !end_done) begin
            chk("queue_empty", sb_q.size(), 32'd0);
            end_done = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a poll for one cycle; the model records it only if the
    // controller should be idle at this cycle
    task automatic issue_poll(input logic [7:0] pat);
        exp_t e;
        if (rst_n && (cyc >= free_at)) begin
            pad_pattern = pat;
            e.start = cyc;
            e.pat   = pat;
            sb_q.push_back(e);
            free_at = cyc + LAT + 1;
        end
        poll = 1'b1;
        step(1);
        poll = 1'b0;
    endtask

    task automatic wait_free();
        while (cyc < free_at) step(1);
    endtask

    task automatic do_reset(input int n);
        rst_n   = 1'b0;
        free_at = 0;
        step(n);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        // Reset for 3 cycles, then 5000 quiet cycles
        step(3);
        rst_n = 1'b1;
        step(5000);

        // Single poll with a busy-time poll that must be dropped
        issue_poll(8'hA5);
        step(999);
        issue_poll(8'h3C);
        wait_free();

        // Reset mid-poll, then a fresh poll
        issue_poll(8'h5A);
        step(1199);
        do_reset(3);
        issue_poll(8'hC3);
        wait_free();

        // Back-to-back: second poll one cycle after valid
        issue_poll(8'h00);
        wait_free();
        issue_poll(8'hFF);
        wait_free();

        // Edge-detect pair
        step(3);
        issue_poll(8'hA5);
        wait_free();
        issue_poll(8'hA7);
        wait_free();

        // Random patterns with dropped polls while busy or in the DONE cycle
        for (int i = 0; i < 6; i++) begin
            logic [7:0] p;
            int         mode;
            int         off;
            p    = 8'($urandom);
            mode = $urandom_range(0, 2);
            issue_poll(p);
            if (mode == 0) begin
                off = $urandom_range(1, LAT - 1);
                step(off - 1);
                issue_poll(~p);
            end else if (mode == 1) begin
                step(LAT - 1);
                issue_poll(~p);
            end
            wait_free();
            step($urandom_range(0, 20));
        end

        step(5);
        end_req = 1'b1;
        step(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
